dct_zigzag_serializer: RTL and testbench

- Receive side of the 2-D DCT row-output interface: accepts one 8-coefficient row per i_valid, 8 rows form one 8x8 block.
- Reorders each block into JPEG zigzag order and streams one coefficient per transfer over a valid/ready link to the quantiser/entropy stage.
- Ping-pong storage (2 banks x 64 x DW) lets block N+1 be written while block N streams out.

---
 rtl/dct_pkg.sv | 30 +++
 rtl/dct_zigzag_serializer_if.sv | 35 +++
 rtl/zz_order_rom.sv | 11 +
 rtl/dct_zigzag_serializer.sv | 202 ++++++++++++++++++++
 tb/tb_dct_zigzag_serializer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_pkg.sv
// Shared DCT-side constants: coefficient width, block geometry and the JPEG zigzag map.
// No logic; imported by the serializer, its address ROM and its interface.
package dct_pkg;

    localparam int DW     = 12;
    localparam int BLK_N  = 8;
    localparam int BLK_SZ = 64;

    // Zigzag position -> row-major address (row*8 + col) within an 8x8 block.
    localparam logic [5:0] ZZ_ADDR [BLK_SZ] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    function automatic logic [5:0] zz_addr(input logic [5:0] idx);
        return ZZ_ADDR[idx];
    endfunction

endpackage

// File: rtl/dct_zigzag_serializer_if.sv
// Row-in / coefficient-out handshake bundle of the zigzag serializer.
// Slave modport is the serializer's view; master is the neighbouring stages' view.
interface dct_zigzag_serializer_if #(
    parameter int DW = dct_pkg::DW
);
    logic                 i_valid;
    logic                 o_ready;
    logic signed [DW-1:0] i_data0;
    logic signed [DW-1:0] i_data1;
    logic signed [DW-1:0] i_data2;
    logic signed [DW-1:0] i_data3;
    logic signed [DW-1:0] i_data4;
    logic signed [DW-1:0] i_data5;
    logic signed [DW-1:0] i_data6;
    logic signed [DW-1:0] i_data7;

    logic                 o_valid;
    logic                 i_ready;
    logic signed [DW-1:0] o_data;
    logic [5:0]           o_zz_index;
    logic                 o_last;

    modport slave (
        input  i_valid, i_data0, i_data1, i_data2, i_data3,
               i_data4, i_data5, i_data6, i_data7, i_ready,
        output o_ready, o_valid, o_data, o_zz_index, o_last
    );

    modport master (
        output i_valid, i_data0, i_data1, i_data2, i_data3,
               i_data4, i_data5, i_data6, i_data7, i_ready,
        input  o_ready, o_valid, o_data, o_zz_index, o_last
    );

endinterface

// File: rtl/zz_order_rom.sv
// Zigzag position to row-major block address lookup.
// Latency: combinational. Backpressure: none (pure lookup).
module zz_order_rom (
    input  logic [5:0] idx,
    output logic [5:0] addr
);
    import dct_pkg::*;

    assign addr = zz_addr(idx);

endmodule

// File: rtl/dct_zigzag_serializer.sv
// 8x8 DCT row collector that streams each block in JPEG zigzag order; optional DCT_ZZ_ROUND_SHIFT_EN rounding shift.
// Latency: first coefficient valid 2 cycles after row 7 is accepted; then 1 coefficient/cycle.
// Backpressure: o_ready drops while both ping-pong banks hold blocks; outputs hold while i_ready is low.
module dct_zigzag_serializer #(
    parameter int DW     = dct_pkg::DW,
    parameter int QSHIFT = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    dct_zigzag_serializer_if.slave  zz,
    output logic                    o_overflow
);
    import dct_pkg::*;

    if (QSHIFT < 0 || QSHIFT >= DW) begin : g_bad_qshift
        $error("QSHIFT must lie in [0, DW)");
    end

    logic signed [DW-1:0] row [BLK_N];
    logic signed [DW-1:0] mem [2][BLK_SZ];

    logic [1:0]           full;
    logic                 wbank;
    logic                 rbank;
    logic [2:0]           row_cnt;
    logic                 row_acc;
    logic                 row_done;

    rd_state_t            state;
    rd_state_t            state_nxt;
    logic                 xfer;
    logic                 blk_done;
    logic                 other_full;
    logic                 ld_en;
    logic                 ld_bank;
    logic [5:0]           ld_idx;
    logic [5:0]           ld_addr;
    logic signed [DW-1:0] rd_coef;
    logic signed [DW-1:0] shaped;

    logic                 valid_q;
    logic signed [DW-1:0] data_q;
    logic [5:0]           idx_q;
    logic                 last_q;

    assign row[0] = zz.i_data0;
    assign row[1] = zz.i_data1;
    assign row[2] = zz.i_data2;
    assign row[3] = zz.i_data3;
    assign row[4] = zz.i_data4;
    assign row[5] = zz.i_data5;
    assign row[6] = zz.i_data6;
    assign row[7] = zz.i_data7;

    assign zz.o_ready = !full[wbank];
    assign row_acc    = zz.i_valid && zz.o_ready;
    assign row_done   = row_acc && (row_cnt == 3'(BLK_N - 1));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            row_cnt    <= '0;
            wbank      <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (row_acc) begin
                row_cnt <= row_cnt + 3'd1;
            end
            if (row_done) begin
                wbank <= ~wbank;
            end
            if (zz.i_valid && !zz.o_ready) begin
                o_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (row_acc) begin
            for (int c = 0; c < BLK_N; c++) begin
                mem[wbank][{row_cnt, 3'(c)}] <= row[c];
            end
        end
    end

    // Set and clear never target the same bank: a bank being written is never full.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            full  <= 2'b00;
            rbank <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (row_done && wbank == 1'(b)) begin
                    full[b] <= 1'b1;
                end else if (blk_done && rbank == 1'(b)) begin
                    full[b] <= 1'b0;
                end
            end
            if (blk_done) begin
                rbank <= ~rbank;
            end
        end
    end

    assign xfer       = (state == RD_STREAM) && zz.i_ready;
    assign blk_done   = xfer && (idx_q == 6'd63);
    assign other_full = full[~rbank];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= RD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE:   if (full[rbank]) state_nxt = RD_STREAM;
            RD_STREAM: if (blk_done && !other_full) state_nxt = RD_IDLE;
            default:   state_nxt = RD_IDLE;
        endcase
    end

    // Pick which coefficient, if any, the output register captures this cycle.
    always_comb begin
        ld_en   = 1'b0;
        ld_idx  = '0;
        ld_bank = rbank;
        case (state)
            RD_IDLE: begin
                ld_en = full[rbank];
            end
            RD_STREAM: begin
                if (xfer) begin
                    if (idx_q != 6'd63) begin
                        ld_en  = 1'b1;
                        ld_idx = idx_q + 6'd1;
                    end else if (other_full) begin
                        ld_en   = 1'b1;
                        ld_bank = ~rbank;
                    end
                end
            end
            default: ;
        endcase
    end

    zz_order_rom u_zz_order_rom (
        .idx  (ld_idx),
        .addr (ld_addr)
    );

    assign rd_coef = mem[ld_bank][ld_addr];

`ifdef DCT_ZZ_ROUND_SHIFT_EN
    localparam int             RND     = (1 << QSHIFT) >> 1;
    localparam logic [DW+1:0]  MAX_POS = (DW+2)'((1 << (DW - 1)) - 1);
    localparam logic [DW+1:0]  MAX_NEG = (DW+2)'(1 << (DW - 1));

    // Round half away from zero: shift the magnitude, then restore the sign.
    function automatic logic signed [DW-1:0] round_shift(input logic signed [DW-1:0] x);
        logic signed [DW:0] xe;
        logic [DW+1:0]      sum;
        logic [DW+1:0]      q;
        xe  = x;
        sum = {1'b0, (xe[DW] ? -xe : xe)} + (DW+2)'(RND);
        q   = sum >> QSHIFT;
        if (!xe[DW]) begin
            return (q > MAX_POS) ? DW'(MAX_POS) : DW'(q);
        end
        return (q > MAX_NEG) ? DW'(MAX_NEG) : DW'(-q);
    endfunction

    assign shaped = round_shift(rd_coef);
`else
    assign shaped = rd_coef;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else if (ld_en) begin
            valid_q <= 1'b1;
            data_q  <= shaped;
            idx_q   <= ld_idx;
            last_q  <= (ld_idx == 6'd63);
        end else if (blk_done) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign zz.o_valid    = valid_q;
    assign zz.o_data     = data_q;
    assign zz.o_zz_index = idx_q;
    assign zz.o_last     = last_q;

endmodule

// File: tb/tb_dct_zigzag_serializer.sv
// Bench for dct_zigzag_serializer: scoreboard built from a diagonal-walk zigzag model,
// directed block sequences, a value table and randomized row/ready traffic.
module tb_dct_zigzag_serializer;

    localparam int W = 12;
`ifdef DCT_ZZ_ROUND_SHIFT_EN
    localparam int QS       = 2;
    localparam bit SHIFT_ON = 1'b1;
`else
    localparam int QS       = 0;
    localparam bit SHIFT_ON = 1'b0;
`endif

    typedef struct { int data; int idx; bit last; } exp_t;
    typedef struct { int din; int dout; } vec_t;

    logic clk;
    logic rst_n;
    logic ovf;

    dct_zigzag_serializer_if #(.DW(W)) zif ();

    dct_zigzag_serializer #(.DW(W), .QSHIFT(QS)) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .zz         (zif),
        .o_overflow (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk, n_err, cyc;
    int   zz_map [64];
    int   part [$];
    exp_t exp_q [$];
    int   pending;
    bit   m_ovf;
    int   cur_row [8];
    bit   hold_pend;
    int   h_data, h_idx;
    bit   h_last;
    int   first_valid_cyc, xfer_cnt, first_xfer_cyc, last_xfer_cyc;
    bit   tab_on;
    int   tab_expect, tab_bad;
    vec_t vtab [6];

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Zigzag order by walking anti-diagonals, alternating direction.
    function automatic void build_zz();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz_map[k] = r * 8 + (s - r); k++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz_map[k] = r * 8 + (s - r); k++; end
            end
        end
    endfunction

    function automatic int ref_shape(input int x);
        int a, q;
        if (!SHIFT_ON || QS == 0) return x;
        a = (x < 0) ? -x : x;
        q = (a + (1 << QS) / 2) / (1 << QS);
        if (x < 0) q = -q;
        if (q > 2 ** (W - 1) - 1) q = 2 ** (W - 1) - 1;
        if (q < -(2 ** (W - 1))) q = -(2 ** (W - 1));
        return q;
    endfunction

    function automatic void model_accept();
        exp_t e;
        for (int c = 0; c < 8; c++) part.push_back(cur_row[c]);
        if (part.size() == 64) begin
            for (int k = 0; k < 64; k++) begin
                e.data = ref_shape(part[zz_map[k]]);
                e.idx  = k;
                e.last = (k == 63);
                exp_q.push_back(e);
            end
            part.delete();
            pending++;
        end
    endfunction

    function automatic void model_reset();
        part.delete();
        exp_q.delete();
        pending   = 0;
        m_ovf     = 1'b0;
        hold_pend = 1'b0;
    endfunction

    function automatic void clear_stats();
        first_valid_cyc = -1;
        xfer_cnt        = 0;
        first_xfer_cyc  = 0;
        last_xfer_cyc   = 0;
    endfunction

    task automatic step(input bit v, input bit rdy);
        exp_t e;
        @(negedge clk);
        cyc++;
        if (hold_pend)
            chk(zif.o_valid === 1'b1 && int'(zif.o_data) == h_data &&
                int'(zif.o_zz_index) == h_idx && zif.o_last === h_last,
                "hold_stable", int'(zif.o_data), h_data);
        chk(zif.o_ready === (pending < 2), "o_ready", int'(zif.o_ready), int'(pending < 2));
        chk(ovf === m_ovf, "o_overflow", int'(ovf), int'(m_ovf));
        zif.i_valid = v;
        zif.i_ready = rdy;
        zif.i_data0 = W'(cur_row[0]);
        zif.i_data1 = W'(cur_row[1]);
        zif.i_data2 = W'(cur_row[2]);
        zif.i_data3 = W'(cur_row[3]);
        zif.i_data4 = W'(cur_row[4]);
        zif.i_data5 = W'(cur_row[5]);
        zif.i_data6 = W'(cur_row[6]);
        zif.i_data7 = W'(cur_row[7]);
        if (zif.o_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (v) begin
            if (zif.o_ready === 1'b1) model_accept();
            else m_ovf = 1'b1;
        end
        hold_pend = (zif.o_valid === 1'b1) && !rdy;
        h_data    = int'(zif.o_data);
        h_idx     = int'(zif.o_zz_index);
        h_last    = zif.o_last;
        if (zif.o_valid === 1'b1 && rdy) begin
            if (tab_on && int'(zif.o_data) != tab_expect) tab_bad++;
            if (xfer_cnt == 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            xfer_cnt++;
            chk(exp_q.size() != 0, "coef_expected", int'(zif.o_data), 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(int'(zif.o_data) == e.data, "coef_data", int'(zif.o_data), e.data);
                chk(int'(zif.o_zz_index) == e.idx, "coef_index", int'(zif.o_zz_index), e.idx);
                chk(zif.o_last === e.last, "coef_last", int'(zif.o_last), int'(e.last));
                if (e.last) pending--;
            end
        end
    endtask

    // mode 0: ready always, 1: ready toggles every cycle, 2: random ready
    task automatic drain(input int mode);
        int  n = 0;
        bit  r;
        while ((exp_q.size() != 0 || zif.o_valid === 1'b1) && n < 400) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom % 2 == 0);
            step(1'b0, r);
            n++;
        end
        chk(n < 400, "drain_timeout", n, 400);
    endtask

    task automatic send_inc_block(input bit rdy, output int acc_cyc);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) cur_row[c] = r * 8 + c;
            step(1'b1, rdy);
        end
        acc_cyc = cyc;
    endtask

    task automatic set_random_row();
        for (int c = 0; c < 8; c++) cur_row[c] = int'($urandom_range(4095)) - 2048;
    endtask

    task automatic check_reset_values(input string tag);
        chk(zif.o_valid === 1'b0, {tag, "_o_valid"}, int'(zif.o_valid), 0);
        chk(zif.o_data === '0, {tag, "_o_data"}, int'(zif.o_data), 0);
        chk(zif.o_zz_index === '0, {tag, "_o_zz_index"}, int'(zif.o_zz_index), 0);
        chk(zif.o_last === 1'b0, {tag, "_o_last"}, int'(zif.o_last), 0);
        chk(zif.o_ready === 1'b1, {tag, "_o_ready"}, int'(zif.o_ready), 1);
        chk(ovf === 1'b0, {tag, "_o_overflow"}, int'(ovf), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc7, n;
        n_chk = 0; n_err = 0; cyc = 0;
        tab_on = 1'b0; tab_bad = 0; tab_expect = 0;
        build_zz();
        model_reset();
        clear_stats();
        for (int c = 0; c < 8; c++) cur_row[c] = 0;
`ifdef DCT_ZZ_ROUND_SHIFT_EN
        vtab[0] = '{-6, -2};     vtab[1] = '{6, 2};      vtab[2] = '{2047, 512};
        vtab[3] = '{-2048, -512}; vtab[4] = '{2, 1};     vtab[5] = '{1, 0};
`else
        vtab[0] = '{-2048, -2048}; vtab[1] = '{2047, 2047}; vtab[2] = '{-1, -1};
        vtab[3] = '{0, 0};         vtab[4] = '{1, 1};       vtab[5] = '{1365, 1365};
`endif

        zif.i_valid = 1'b0; zif.i_ready = 1'b0;
        zif.i_data0 = '0; zif.i_data1 = '0; zif.i_data2 = '0; zif.i_data3 = '0;
        zif.i_data4 = '0; zif.i_data5 = '0; zif.i_data6 = '0; zif.i_data7 = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Ramp block, continuous ready: latency, order, o_last, no gaps.
        clear_stats();
        send_inc_block(1'b1, acc7);
        drain(0);
        chk(first_valid_cyc - acc7 == 2, "first_valid_latency", first_valid_cyc - acc7, 2);
        chk(xfer_cnt == 64, "blk1_count", xfer_cnt, 64);
        chk(last_xfer_cyc - first_xfer_cyc == 63, "blk1_span", last_xfer_cyc - first_xfer_cyc, 63);

        // Same block with ready toggling every cycle.
        clear_stats();
        send_inc_block(1'b0, acc7);
        drain(1);
        chk(xfer_cnt == 64, "toggle_count", xfer_cnt, 64);

        // Two blocks back to back: no bubble between index 63 and 0.
        clear_stats();
        for (int r = 0; r < 16; r++) begin
            set_random_row();
            step(1'b1, 1'b1);
        end
        drain(0);
        chk(xfer_cnt == 128, "b2b_count", xfer_cnt, 128);
        chk(last_xfer_cyc - first_xfer_cyc == 127, "b2b_span", last_xfer_cyc - first_xfer_cyc, 127);

        // 17 rows with the sink stalled: row 17 must be dropped and flagged.
        clear_stats();
        for (int r = 0; r < 17; r++) begin
            if (r == 16) for (int c = 0; c < 8; c++) cur_row[c] = 777;
            else set_random_row();
            step(1'b1, 1'b0);
        end
        step(1'b0, 1'b0);
        chk(zif.o_ready === 1'b0, "ovf_ready_low", int'(zif.o_ready), 0);
        chk(ovf === 1'b1, "ovf_sticky", int'(ovf), 1);
        drain(0);
        chk(xfer_cnt == 128, "ovf_two_blocks", xfer_cnt, 128);

        // Value table: a block filled with one value must stream that value's image.
        for (int t = 0; t < 6; t++) begin
            for (int c = 0; c < 8; c++) cur_row[c] = vtab[t].din;
            for (int r = 0; r < 8; r++) step(1'b1, 1'b1);
            tab_on = 1'b1; tab_expect = vtab[t].dout; tab_bad = 0;
            drain(0);
            tab_on = 1'b0;
            chk(tab_bad == 0, "table_value", tab_bad, 0);
        end

        // Asynchronous reset while index 30 is on the output.
        send_inc_block(1'b1, acc7);
        n = 0;
        while (!(zif.o_valid === 1'b1 && zif.o_zz_index == 6'd29) && n < 200) begin
            step(1'b0, 1'b1);
            n++;
        end
        chk(n < 200, "reach_idx29_timeout", n, 200);
        @(posedge clk);
        #2;
        chk(zif.o_zz_index == 6'd30, "pre_reset_idx", int'(zif.o_zz_index), 30);
        rst_n = 1'b0;
        zif.i_valid = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        send_inc_block(1'b1, acc7);
        drain(0);
        chk(xfer_cnt == 64, "post_reset_count", xfer_cnt, 64);

        // Random rows and ready.
        for (int i = 0; i < 800; i++) begin
            set_random_row();
            step(($urandom % 4) != 0, ($urandom % 3) != 0);
        end
        drain(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
